// File: rtl/pipe_stage_buf_pkg.sv
// Shared pipeline package: stage-buffer occupancy encoding and default bubble payload.
package pipe_stage_buf_pkg;

    localparam int unsigned DEFAULT_DATA_W = 64;
    localparam int unsigned COUNT_W        = 2;

    // Occupancy state; the encoding doubles as the held-entry count.
    typedef enum logic [COUNT_W-1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } bufState_t;

    // Bubble payload shown on an empty stage.
    localparam logic [DEFAULT_DATA_W-1:0] NOP_DEFAULT = '0;

endpackage

// File: rtl/pipe_slot_reg.sv
// One pipeline slot: DATA_W-wide register with load enable, async clear to NOP_VAL.
module pipe_slot_reg
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned           DATA_W  = DEFAULT_DATA_W,
    parameter logic [DATA_W-1:0]     NOP_VAL = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Capture d on load; reset forces the bubble value.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= NOP_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_stage_buf.sv
// Pipeline stage buffer: two-entry skid buffer (SKID=1) or single slot (SKID=0),
// with stall freeze and flush.
module pipe_stage_buf
    import pipe_stage_buf_pkg::*;
#(
    parameter int unsigned       DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned       SKID    = 1,
    parameter logic [DATA_W-1:0] NOP_VAL = DATA_W'(NOP_DEFAULT)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_valid,
    output logic              o_ready,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_valid,
    input  logic              i_ready,
    output logic [DATA_W-1:0] o_data,
    input  logic              i_stall,
    input  logic              i_flush,
    output logic [1:0]        o_count
);

    bufState_t         stateQ;
    bufState_t         nextState;
    logic              accept;
    logic              release_;
    logic              headLoad;
    logic [DATA_W-1:0] headD;
    logic              skidLoad;
    logic [DATA_W-1:0] skidD;
    logic [DATA_W-1:0] skidQ;

    // Status decoded straight from the state register.
    assign o_valid = (stateQ != EMPTY);
    assign o_count = 2'(stateQ);

    // Ready: SKID=1 looks only at registered state; SKID=0 lets a releasing slot refill.
    generate
        if (SKID != 0) begin : gSkidReady
            assign o_ready = ~rst & ~i_stall & (stateQ != FULL);
        end else begin : gSlotReady
            assign o_ready = ~rst & ~i_stall & (~o_valid | i_ready);
        end
    endgenerate

    assign accept   = i_valid & o_ready;
    assign release_ = o_valid & i_ready & ~i_stall;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stateQ <= EMPTY;
        end else begin
            stateQ <= nextState;
        end
    end

    // Next-state: flush wins over everything, including a stalled cycle.
    always_comb begin
        nextState = stateQ;
        if (i_flush) begin
            nextState = EMPTY;
        end else begin
            case (stateQ)
                EMPTY: if (accept) nextState = ONE;
                ONE: begin
                    if (accept && !release_)      nextState = FULL;
                    else if (!accept && release_) nextState = EMPTY;
                end
                FULL: if (release_) nextState = ONE;
                default: nextState = EMPTY;
            endcase
        end
    end

    // Slot controls: head always holds the oldest entry, freed slots return to NOP_VAL.
    always_comb begin
        headLoad = 1'b0;
        headD    = NOP_VAL;
        skidLoad = 1'b0;
        skidD    = NOP_VAL;
        if (i_flush) begin
            headLoad = 1'b1;
            skidLoad = 1'b1;
        end else begin
            case (stateQ)
                EMPTY: begin
                    if (accept) begin
                        headLoad = 1'b1;
                        headD    = i_data;
                    end
                end
                ONE: begin
                    if (accept && release_) begin
                        headLoad = 1'b1;
                        headD    = i_data;
                    end else if (accept) begin
                        skidLoad = 1'b1;
                        skidD    = i_data;
                    end else if (release_) begin
                        headLoad = 1'b1;
                    end
                end
                FULL: begin
                    if (release_) begin
                        headLoad = 1'b1;
                        headD    = skidQ;
                        skidLoad = 1'b1;
                    end
                end
                default: begin
                    headLoad = 1'b1;
                    skidLoad = 1'b1;
                end
            endcase
        end
    end

    // Head slot drives o_data directly.
    pipe_slot_reg #(
        .DATA_W  (DATA_W),
        .NOP_VAL (NOP_VAL)
    ) uHead (
        .clk  (clk),
        .rst  (rst),
        .load (headLoad),
        .d    (headD),
        .q    (o_data)
    );

    // Skid slot holds the second entry while the head is blocked.
    pipe_slot_reg #(
        .DATA_W  (DATA_W),
        .NOP_VAL (NOP_VAL)
    ) uSkid (
        .clk  (clk),
        .rst  (rst),
        .load (skidLoad),
        .d    (skidD),
        .q    (skidQ)
    );

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: vector table on a SKID=1 instance, hand sequences
// for async reset, and a scoreboard run on a SKID=0 instance.
module tb_pipe_stage_buf;

    localparam logic [15:0] NOP_A = 16'hDEAD;
    localparam logic [15:0] NOP_B = 16'h0000;
    localparam int unsigned NVEC  = 27;

    logic clk;
    logic rst;

    // SKID=1 instance signals
    logic        aValid, aReady, aOValid, aIReady, aStall, aFlush;
    logic [15:0] aData, aOData;
    logic [1:0]  aCount;

    // SKID=0 instance signals
    logic        bValid, bReady, bOValid, bIReady, bStall, bFlush;
    logic [15:0] bData, bOData;
    logic [1:0]  bCount;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        v;
        logic        r;
        logic        s;
        logic        f;
        logic [15:0] d;
        logic        eRdy;
        logic        eVal;
        logic [15:0] eData;
        logic [1:0]  eCnt;
    } vec_t;

    vec_t vecs [NVEC];

    pipe_stage_buf #(.DATA_W(16), .SKID(1), .NOP_VAL(NOP_A)) dutA (
        .clk(clk), .rst(rst),
        .i_valid(aValid), .o_ready(aReady), .i_data(aData),
        .o_valid(aOValid), .i_ready(aIReady), .o_data(aOData),
        .i_stall(aStall), .i_flush(aFlush), .o_count(aCount)
    );

    pipe_stage_buf #(.DATA_W(16), .SKID(0), .NOP_VAL(NOP_B)) dutB (
        .clk(clk), .rst(rst),
        .i_valid(bValid), .o_ready(bReady), .i_data(bData),
        .o_valid(bOValid), .i_ready(bIReady), .o_data(bOData),
        .i_stall(bStall), .i_flush(bFlush), .o_count(bCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic v, input logic r, input logic s, input logic f,
                                input logic [15:0] d, input logic eRdy, input logic eVal,
                                input logic [15:0] eData, input logic [1:0] eCnt);
        vec_t t;
        t.v = v; t.r = r; t.s = s; t.f = f; t.d = d;
        t.eRdy = eRdy; t.eVal = eVal; t.eData = eData; t.eCnt = eCnt;
        return t;
    endfunction

    task automatic driveA(input logic v, input logic r, input logic s, input logic f,
                          input logic [15:0] d);
        aValid = v; aIReady = r; aStall = s; aFlush = f; aData = d;
    endtask

    initial begin
        logic [15:0] q[$];
        logic [15:0] nextData;
        logic        expRdy;
        logic        acc;
        logic        rel;
        logic        rdy;
        logic        stl;
        int          pushed;
        int          popped;

        //           v  r  s  f  data      rdy val data    cnt
        vecs[0]  = mk(1, 1, 0, 0, 16'h0001, 1, 1, 16'h0001, 2'd1);
        vecs[1]  = mk(1, 1, 0, 0, 16'h0002, 1, 1, 16'h0002, 2'd1);
        vecs[2]  = mk(1, 1, 0, 0, 16'h0003, 1, 1, 16'h0003, 2'd1);
        vecs[3]  = mk(0, 1, 0, 0, 16'h0000, 1, 0, NOP_A,    2'd0);
        vecs[4]  = mk(1, 0, 0, 0, 16'h000A, 1, 1, 16'h000A, 2'd1);
        vecs[5]  = mk(1, 0, 0, 0, 16'h000B, 1, 1, 16'h000A, 2'd2);
        vecs[6]  = mk(1, 0, 0, 0, 16'h000C, 0, 1, 16'h000A, 2'd2);
        vecs[7]  = mk(1, 1, 0, 0, 16'h000C, 0, 1, 16'h000B, 2'd1);
        vecs[8]  = mk(1, 1, 0, 0, 16'h000C, 1, 1, 16'h000C, 2'd1);
        vecs[9]  = mk(0, 1, 0, 0, 16'h0000, 1, 0, NOP_A,    2'd0);
        vecs[10] = mk(1, 0, 0, 0, 16'h0005, 1, 1, 16'h0005, 2'd1);
        vecs[11] = mk(1, 1, 1, 0, 16'h0006, 0, 1, 16'h0005, 2'd1);
        vecs[12] = mk(1, 1, 1, 0, 16'h0006, 0, 1, 16'h0005, 2'd1);
        vecs[13] = mk(1, 1, 1, 0, 16'h0006, 0, 1, 16'h0005, 2'd1);
        vecs[14] = mk(1, 1, 0, 0, 16'h0006, 1, 1, 16'h0006, 2'd1);
        vecs[15] = mk(0, 1, 0, 0, 16'h0000, 1, 0, NOP_A,    2'd0);
        vecs[16] = mk(1, 0, 0, 0, 16'h0007, 1, 1, 16'h0007, 2'd1);
        vecs[17] = mk(1, 0, 0, 0, 16'h0008, 1, 1, 16'h0007, 2'd2);
        vecs[18] = mk(1, 1, 1, 1, 16'h0009, 0, 0, NOP_A,    2'd0);
        vecs[19] = mk(1, 0, 0, 1, 16'h0009, 1, 0, NOP_A,    2'd0);
        vecs[20] = mk(0, 1, 0, 0, 16'h0000, 1, 0, NOP_A,    2'd0);
        vecs[21] = mk(1, 0, 0, 0, 16'h0011, 1, 1, 16'h0011, 2'd1);
        vecs[22] = mk(1, 1, 0, 1, 16'h0012, 1, 0, NOP_A,    2'd0);
        vecs[23] = mk(1, 0, 0, 0, 16'h0021, 1, 1, 16'h0021, 2'd1);
        vecs[24] = mk(1, 0, 0, 0, 16'h0022, 1, 1, 16'h0021, 2'd2);
        vecs[25] = mk(0, 1, 0, 0, 16'h0000, 0, 1, 16'h0022, 2'd1);
        vecs[26] = mk(0, 1, 0, 0, 16'h0000, 1, 0, NOP_A,    2'd0);

        rst = 1'b1;
        driveA(0, 0, 0, 0, 16'h0);
        bValid = 1'b0; bIReady = 1'b0; bStall = 1'b0; bFlush = 1'b0; bData = 16'h0;

        // Reset state while rst is held
        @(negedge clk);
        @(negedge clk);
        check("rst_ready", 16'(aReady), 16'd0);
        check("rst_valid", 16'(aOValid), 16'd0);
        check("rst_data", aOData, NOP_A);
        check("rst_count", 16'(aCount), 16'd0);
        check("rst_b_ready", 16'(bReady), 16'd0);
        rst = 1'b0;

        // Vector table on the SKID=1 instance
        for (int i = 0; i < NVEC; i++) begin
            driveA(vecs[i].v, vecs[i].r, vecs[i].s, vecs[i].f, vecs[i].d);
            #1;
            check($sformatf("v%0d_ready", i), 16'(aReady), 16'(vecs[i].eRdy));
            @(posedge clk);
            @(negedge clk);
            check($sformatf("v%0d_valid", i), 16'(aOValid), 16'(vecs[i].eVal));
            check($sformatf("v%0d_data", i), aOData, vecs[i].eData);
            check($sformatf("v%0d_count", i), 16'(aCount), 16'(vecs[i].eCnt));
        end

        // Async reset pulsed between edges while the buffer is full
        driveA(1, 0, 0, 0, 16'h0041);
        @(posedge clk);
        @(negedge clk);
        driveA(1, 0, 0, 0, 16'h0042);
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_count", 16'(aCount), 16'd2);
        driveA(0, 0, 0, 0, 16'h0);
        #1 rst = 1'b1;
        #1;
        check("mid_rst_valid", 16'(aOValid), 16'd0);
        check("mid_rst_data", aOData, NOP_A);
        check("mid_rst_count", 16'(aCount), 16'd0);
        check("mid_rst_ready", 16'(aReady), 16'd0);
        #1 rst = 1'b0;
        #1;
        check("post_rst_ready", 16'(aReady), 16'd1);
        driveA(1, 0, 0, 0, 16'h0043);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_data", aOData, 16'h0043);
        check("post_rst_count", 16'(aCount), 16'd1);
        driveA(0, 1, 0, 0, 16'h0);
        @(posedge clk);
        @(negedge clk);
        check("post_rst_drain_data", aOData, NOP_A);
        check("post_rst_drain_count", 16'(aCount), 16'd0);
        driveA(0, 0, 0, 0, 16'h0);

        // SKID=0 scoreboard: i_ready cycles 1,0,1 under continuous i_valid, with a stall window
        nextData = 16'h0100;
        pushed   = 0;
        popped   = 0;
        for (int c = 0; c < 34; c++) begin
            rdy = ((c % 3) != 1) || (c >= 30);
            stl = (c == 20) || (c == 21);
            bValid  = (c < 30);
            bIReady = rdy;
            bStall  = stl;
            bData   = nextData;
            #1;
            expRdy = ~stl & ((q.size() == 0) | rdy);
            check($sformatf("s0_c%0d_ready", c), 16'(bReady), 16'(expRdy));
            check($sformatf("s0_c%0d_valid", c), 16'(bOValid), 16'(q.size() != 0));
            check($sformatf("s0_c%0d_data", c), bOData, (q.size() != 0) ? q[0] : NOP_B);
            acc = bValid & expRdy;
            rel = (q.size() != 0) & rdy & ~stl;
            @(posedge clk);
            if (rel) begin
                void'(q.pop_front());
                popped++;
            end
            if (acc) begin
                q.push_back(nextData);
                nextData = nextData + 16'h1;
                pushed++;
            end
            @(negedge clk);
        end
        check("s0_count_empty", 16'(bCount), 16'd0);
        check("s0_in_eq_out", 16'(popped), 16'(pushed));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
